// File: rtl/scmi_channel_arbiter.sv
// Round-robin owner arbitration for one shared SCMI mailbox channel, sequencing
// doorbell/completion toward the platform with a watchdog that frees a stuck channel.
module scmi_channel_arbiter #(
  parameter  int NUM_AGENTS     = 4,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int ID_W           = $clog2(NUM_AGENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_AGENTS-1:0] req_i,
  input  logic [NUM_AGENTS-1:0] done_i,
  input  logic                  completion_i,
  output logic [NUM_AGENTS-1:0] grant_o,
  output logic [ID_W-1:0]       owner_id_o,
  output logic                  doorbell_o,
  output logic [NUM_AGENTS-1:0] completion_o,
  output logic [NUM_AGENTS-1:0] timeout_o,
  output logic                  chan_free_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_AGENTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_RING,
    S_WAIT,
    S_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            cmpl_q, cmpl_d;  // release cause: 1 = completion, 0 = watchdog

  logic            any_req;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] idx;
  logic [NUM_AGENTS-1:0] owner_oh;

  // First requester at or after ptr, wrapping around the agent range.
  always_comb begin
    any_req = 1'b0;
    win_id  = ptr_q;
    idx     = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      idx = ID_W'((int'(ptr_q) + i) % NUM_AGENTS);
      if (!any_req && req_i[idx]) begin
        any_req = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    cmpl_d  = cmpl_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = win_id;
          ptr_d   = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (done_i[owner_q]) begin
          state_d = S_RING;
        end else if (!req_i[owner_q]) begin
          state_d = S_IDLE;
        end
      end
      S_RING: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (completion_i) begin
          cmpl_d  = 1'b1;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          cmpl_d  = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      cmpl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      cmpl_q  <= cmpl_d;
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign grant_o      = (state_q inside {S_GRANT, S_RING, S_WAIT}) ? owner_oh : '0;
  assign owner_id_o   = owner_q;
  assign doorbell_o   = (state_q == S_RING);
  assign completion_o = (state_q == S_RELEASE &&  cmpl_q) ? owner_oh : '0;
  assign timeout_o    = (state_q == S_RELEASE && !cmpl_q) ? owner_oh : '0;
  assign chan_free_o  = (state_q == S_IDLE);

endmodule

// File: tb/tb_scmi_channel_arbiter.sv
// Randomized bench: the driver predicts every output event (grant, doorbell,
// completion, timeout, channel-free) into a queue; a monitor pops and compares.
module tb_scmi_channel_arbiter;

  localparam int N   = 4;
  localparam int T   = 8;
  localparam int K_G = 0;
  localparam int K_D = 1;
  localparam int K_C = 2;
  localparam int K_T = 3;
  localparam int K_F = 4;

  typedef struct {
    int kind;
    int agent;
    int cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] req_i;
  logic [N-1:0] done_i;
  logic         completion_i;
  logic [N-1:0] grant_o;
  logic [1:0]   owner_id_o;
  logic         doorbell_o;
  logic [N-1:0] completion_o;
  logic [N-1:0] timeout_o;
  logic         chan_free_o;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    ptr_m  = 0;
  bit    mon_en = 1'b0;
  ev_t   exp_q[$];
  string kname[5] = '{"grant", "doorbell", "completion", "timeout", "free"};

  always #5 clk = ~clk;

  scmi_channel_arbiter #(
    .NUM_AGENTS    (N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .done_i      (done_i),
    .completion_i(completion_i),
    .grant_o     (grant_o),
    .owner_id_o  (owner_id_o),
    .doorbell_o  (doorbell_o),
    .completion_o(completion_o),
    .timeout_o   (timeout_o),
    .chan_free_o (chan_free_o)
  );

  function automatic int dec(input logic [N-1:0] v);
    int r = -1;
    int n = 0;
    logic [N-1:0] sh;
    for (int i = 0; i < N; i++) begin
      sh = v >> i;
      if (sh[0] === 1'b1) begin
        r = i;
        n++;
      end
    end
    return (n == 1) ? r : -1;
  endfunction

  // Round-robin reference: first set bit at index >= ptr, wrapping.
  function automatic int winner(input logic [N-1:0] m);
    logic [N-1:0] sh;
    for (int i = 0; i < N; i++) begin
      sh = m >> ((ptr_m + i) % N);
      if (sh[0]) return (ptr_m + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rnd();
    return N'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int k, input int a, input int c);
    ev_t e;
    e.kind  = k;
    e.agent = a;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input int a);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got agent %0d at cycle %0d, nothing expected", kname[k], a, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.agent != a || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s agent %0d cycle %0d, expected %s agent %0d cycle %0d",
                 kname[k], a, cyc, kname[e.kind], e.agent, e.cyc);
      end
    end
  endtask

  task automatic chk_reset();
    chk("rst_grant", int'(grant_o), 0);
    chk("rst_owner_id", int'(owner_id_o), 0);
    chk("rst_doorbell", int'(doorbell_o), 0);
    chk("rst_completion", int'(completion_o), 0);
    chk("rst_timeout", int'(timeout_o), 0);
    chk("rst_chan_free", int'(chan_free_o), 1);
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] d, input logic c);
    req_i        = r;
    done_i       = d;
    completion_i = c;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic c);
    @(negedge clk);
    set_in(r, d, c);
  endtask

  // mode: 0 = completion after kc WAIT cycles (0 = random), 1 = watchdog,
  // 2 = abort in GRANT, 3 = reset during WAIT.
  task automatic transfer(input logic [N-1:0] mask, input int mode, input int kc);
    int           w;
    int           k;
    int           dcyc;
    logic [N-1:0] own;
    w   = winner(mask);
    own = N'(1) << w;
    drive(mask, rnd(), rbit());
    expect_ev(K_G, w, cyc + 1);
    ptr_m = (w + 1) % N;
    @(negedge clk);
    chk("owner_id", int'(owner_id_o), w);
    chk("chan_busy", int'(chan_free_o), 0);
    set_in(rnd() | own, rnd() & ~own, rbit());
    repeat ($urandom_range(0, 2)) drive(rnd() | own, rnd() & ~own, rbit());
    if (mode == 2) begin
      drive(rnd() & ~own, rnd() & ~own, rbit());
      expect_ev(K_F, -1, cyc + 1);
      return;
    end
    drive(rnd() | own, rnd() | own, rbit());
    dcyc = cyc + 1;
    expect_ev(K_D, -1, dcyc);
    drive(rnd(), rnd(), rbit());
    if (mode == 3) begin
      repeat ($urandom_range(1, 3)) drive(rnd(), rnd(), 1'b0);
      @(negedge clk);
      rst_i = 1'b1;
      set_in(rnd(), rnd(), rbit());
      expect_ev(K_F, -1, cyc + 1);
      ptr_m = 0;
      @(negedge clk);
      rst_i = 1'b0;
      chk_reset();
      set_in('0, '0, 1'b1);
      drive('0, '0, 1'b0);
      return;
    end
    if (mode == 1) begin
      expect_ev(K_T, w, dcyc + 1 + T);
      repeat (T) drive(rnd(), rnd(), 1'b0);
    end else begin
      k = (kc > 0) ? kc : $urandom_range(1, T);
      repeat (k - 1) drive(rnd(), rnd(), 1'b0);
      drive(rnd(), rnd(), 1'b1);
      expect_ev(K_C, w, cyc + 1);
    end
    drive(rnd(), rnd(), rbit());
    expect_ev(K_F, -1, cyc + 1);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic [N-1:0] pg;
    logic         pf;
    pg = '0;
    pf = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        chk("grant_onehot", int'($countones(grant_o) <= 1), 1);
        if (grant_o != '0 && pg == '0) check_ev(K_G, dec(grant_o));
        if (doorbell_o) check_ev(K_D, -1);
        if (completion_o != '0) check_ev(K_C, dec(completion_o));
        if (timeout_o != '0) check_ev(K_T, dec(timeout_o));
        if (chan_free_o && !pf) check_ev(K_F, -1);
      end
      pg = grant_o;
      pf = chan_free_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit: reached cycle %0d, expected completion well before", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    rst_i = 1'b1;
    set_in('0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset();
    rst_i  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) transfer({N{1'b1}}, 0, 0);
    transfer(4'b0100, 2, 0);
    transfer({N{1'b1}}, 0, 0);
    transfer({N{1'b1}}, 1, 0);
    transfer({N{1'b1}}, 0, T);
    repeat (2) drive('0, rnd(), 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] m;
      int           r;
      m = N'($urandom_range(1, (1 << N) - 1));
      r = $urandom_range(0, 9);
      transfer(m, (r < 2) ? 2 : (r < 4) ? 1 : 0, 0);
      repeat ($urandom_range(0, 2)) drive('0, rnd(), rbit());
    end

    transfer({N{1'b1}}, 3, 0);
    transfer({N{1'b1}}, 0, 0);
    repeat (4) drive('0, '0, 1'b0);
    chk("pending_events", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scmi_channel_arbiter.md
# scmi_channel_arbiter

Shares one SCMI mailbox channel (shared-memory payload, doorbell, completion interrupt) between NUM_AGENTS requesters. It grants channel ownership round-robin and sequences the doorbell/completion handshake toward the platform. A watchdog frees the channel when the platform never completes. It sits between the agent-side software/hardware requesters and the mailbox register block, driving the doorbell write strobe and consuming the completion interrupt.

## Interface

- NUM_AGENTS, default 4: number of requesters, ≥2.
- TIMEOUT_CYCLES, default 65535: WAIT cycles before a transfer is abandoned, ≥1.
- ID_W, default $clog2(NUM_AGENTS): owner index width (derived, not overridden).

Ports:

- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_AGENTS  level request for channel ownership, one bit per agent.
- done_i  in  NUM_AGENTS  pulse: owner finished writing the payload, ring the doorbell.
- completion_i  in  1  pulse: platform completion interrupt (already synchronised, single-cycle).
- grant_o  out  NUM_AGENTS  one-hot ownership; all-zero when the channel is unowned.
- owner_id_o  out  ID_W  index of current owner; holds last owner when free.
- doorbell_o  out  1  single-cycle doorbell strobe to the mailbox.
- completion_o  out  NUM_AGENTS  single-cycle pulse to the owner on completion.
- timeout_o  out  NUM_AGENTS  single-cycle pulse to the owner on watchdog expiry.
- chan_free_o  out  1  high when in IDLE.

## Operation

- FSM states: IDLE, GRANT, RING, WAIT, RELEASE.
- IDLE:
  - If any req_i is set, pick the winner round-robin.
  - Winner = first set bit at index ≥ ptr, wrapping modulo NUM_AGENTS.
  - Register owner, set ptr = (winner+1) mod NUM_AGENTS, go to GRANT.
- GRANT:
  - done_i[owner] → RING.
  - req_i[owner] low (abort) → IDLE, with no pulses.
  - done_i from non-owners is ignored.
- RING: doorbell_o high for exactly this cycle → WAIT. Watchdog counter is cleared.
- WAIT: counter increments each cycle.
  - completion_i → RELEASE with completion flag.
  - Counter == TIMEOUT_CYCLES−1 without completion_i → RELEASE with timeout flag.
  - Both in the same cycle: completion wins.
  - req_i changes are ignored; the agent cannot abort after the doorbell.
- RELEASE:
  - Exactly one of completion_o[owner] / timeout_o[owner] pulses this cycle.
  - grant_o is low this cycle.
  - → IDLE.
- grant_o[owner] is high in GRANT, RING and WAIT only.
- completion_i outside WAIT is ignored; it is not queued.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- An agent still requesting in IDLE after RELEASE is eligible again, behind agents that follow it in round-robin order.

## Timing

- Reset values:
  - State IDLE, ptr=0, owner_id_o=0, counter=0.
  - grant_o=0, doorbell_o=0, completion_o=0, timeout_o=0.
  - chan_free_o=1.
- Reset asserted in any state returns to reset values next edge. No pulse is emitted during or after reset.
- All outputs are decoded from registered state/owner only; there is no combinational path from any input to any output.
- Latencies:
  - Request: req_i sampled high at edge t in IDLE → grant_o valid after edge t, chan_free_o low.
  - Doorbell: done_i at edge t in GRANT → doorbell_o high for the cycle after edge t.
  - Completion: completion_i at edge t in WAIT → completion_o pulse the cycle after edge t, grant_o low in that cycle. IDLE and re-arbitration happen the following cycle.
  - Re-grant: minimum spacing between a RELEASE pulse and the next grant is 1 cycle, where the IDLE cycle does the arbitration.
  - Timeout: timeout_o pulses TIMEOUT_CYCLES+1 cycles after the doorbell cycle.

## Test plan

- **Single agent, normal completion** (NUM_AGENTS=4):
  - req_i=0010 → grant_o=0010, owner_id_o=1 one cycle later.
  - done_i=0010 → one doorbell_o pulse.
  - completion_i 5 cycles later → completion_o=0010 one cycle, chan_free_o=1 the cycle after.
- **Round-robin fairness:** req_i=1111 held, each transfer completed → grant order 0,1,2,3,0. No agent is granted twice before all others.
- **Abort:** grant to agent 2, drop req_i[2] before done_i → IDLE in one cycle. No doorbell_o, completion_o or timeout_o. Next arbitration starts at ptr=3.
- **Watchdog:** TIMEOUT_CYCLES=8, doorbell issued, no completion → timeout_o[owner] exactly 9 cycles after the doorbell cycle, then chan_free_o=1.
- **Collision and spurious events:**
  - completion_i coincident with the final timeout cycle → completion_o only, no timeout_o.
  - completion_i in IDLE → ignored.
  - done_i from a non-owner in GRANT → no doorbell.
- **Reset mid-WAIT:** rst_i high one cycle while in WAIT → all outputs at reset values next cycle, ptr=0. A later completion_i produces no pulse.
